id_decode_unit: RTL and testbench

Decode core of the ARM pipeline's ID stage. It combines three parts: instruction control decoding (control_unit), condition-code evaluation against the status register (condition_check), and the 15×32 general-purpose register file with two read ports and one write-back port (register_file). It sits between the IF/ID boundary and the ID/EX pipeline register. The hazard/condition squash mux and the ID/EX register stay outside this block.

---
 rtl/arm_pkg.sv | 53 +++++
 rtl/condition_check.sv | 40 ++++
 rtl/control_unit.sv | 61 ++++++
 rtl/register_file.sv | 29 ++
 rtl/id_decode_unit.sv | 59 +++++
 tb/tb_id_decode_unit.sv | 197 +++++++++++++++++++
 6 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM ID stage: instruction modes, opcodes,
// ALU command codes, condition codes and status-register bit positions.
package arm_pkg;

   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;

   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_TST = 4'b1000;

   localparam logic [3:0] EXE_NOP = 4'b0000;
   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

endpackage

// File: rtl/condition_check.sv
// Combinational evaluation of the instruction condition field against
// the {N,Z,C,V} status flags.
module condition_check
   import arm_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] SR,
   output logic       cond_ok
);

   logic n, z, c, v;

   assign n = SR[SR_N];
   assign z = SR[SR_Z];
   assign c = SR[SR_C];
   assign v = SR[SR_V];

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_EQ: cond_ok = z;
         COND_NE: cond_ok = ~z;
         COND_CS: cond_ok = c;
         COND_CC: cond_ok = ~c;
         COND_MI: cond_ok = n;
         COND_PL: cond_ok = ~n;
         COND_VS: cond_ok = v;
         COND_VC: cond_ok = ~v;
         COND_HI: cond_ok = c & ~z;
         COND_LS: cond_ok = ~c | z;
         COND_GE: cond_ok = (n == v);
         COND_LT: cond_ok = (n != v);
         COND_GT: cond_ok = ~z & (n == v);
         COND_LE: cond_ok = z | (n != v);
         COND_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Combinational instruction decode: mode/op_code/S to ALU command and
// memory, write-back, branch and flag-update controls.
module control_unit
   import arm_pkg::*;
(
   input  logic [1:0] mode,
   input  logic [3:0] op_code,
   input  logic       S,
   output logic [3:0] Execute_command,
   output logic       mem_read,
   output logic       mem_write,
   output logic       WB_enable,
   output logic       B,
   output logic       Update_SR
);

   always_comb begin
      Execute_command = EXE_NOP;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      WB_enable       = 1'b0;
      B               = 1'b0;
      Update_SR       = 1'b0;
      case (mode)
         MODE_DP: begin
            Update_SR = S;
            WB_enable = 1'b1;
            case (op_code)
               OP_MOV:  Execute_command = EXE_MOV;
               OP_MVN:  Execute_command = EXE_MVN;
               OP_ADD:  Execute_command = EXE_ADD;
               OP_ADC:  Execute_command = EXE_ADC;
               OP_SUB:  Execute_command = EXE_SUB;
               OP_SBC:  Execute_command = EXE_SBC;
               OP_AND:  Execute_command = EXE_AND;
               OP_ORR:  Execute_command = EXE_ORR;
               OP_EOR:  Execute_command = EXE_EOR;
               OP_CMP: begin
                  Execute_command = EXE_SUB;
                  WB_enable       = 1'b0;
               end
               OP_TST: begin
                  Execute_command = EXE_AND;
                  WB_enable       = 1'b0;
               end
               default: WB_enable = 1'b0;
            endcase
         end
         MODE_MEM: begin
            // Address is always base + offset, so the ALU adds for both LDR and STR
            Execute_command = EXE_ADD;
            mem_read        = S;
            WB_enable       = S;
            mem_write       = ~S;
         end
         MODE_BR: B = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/register_file.sv
// 15x32 general-purpose registers, two combinational read ports and one
// write port committing on the falling edge so write-back forwards in-cycle.
module register_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src1,
   input  logic [3:0]  src2,
   input  logic [3:0]  Dest_wb,
   input  logic [31:0] Result_WB,
   input  logic        writeBackEn,
   output logic [31:0] reg1,
   output logic [31:0] reg2
);

   logic [31:0] regs_q [15];

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) regs_q[i] <= 32'(i);
      end else if (writeBackEn && Dest_wb != 4'd15) begin
         regs_q[Dest_wb] <= Result_WB;
      end
   end

   // Index 15 (PC slot) is not stored here and reads as zero
   assign reg1 = (src1 == 4'd15) ? 32'd0 : regs_q[src1];
   assign reg2 = (src2 == 4'd15) ? 32'd0 : regs_q[src2];

endmodule

// File: rtl/id_decode_unit.sv
// ID-stage decode core: wires control decode, condition check and the
// register file between the IF/ID and ID/EX boundaries.
module id_decode_unit
   import arm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic [3:0]  op_code,
   input  logic        S,
   input  logic [3:0]  cond,
   input  logic [3:0]  SR,
   input  logic [3:0]  src1,
   input  logic [3:0]  src2,
   input  logic [3:0]  Dest_wb,
   input  logic [31:0] Result_WB,
   input  logic        writeBackEn,
   output logic [3:0]  Execute_command,
   output logic        mem_read,
   output logic        mem_write,
   output logic        WB_enable,
   output logic        B,
   output logic        Update_SR,
   output logic        cond_ok,
   output logic [31:0] reg1,
   output logic [31:0] reg2
);

   control_unit u_control_unit (
      .mode            (mode),
      .op_code         (op_code),
      .S               (S),
      .Execute_command (Execute_command),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .WB_enable       (WB_enable),
      .B               (B),
      .Update_SR       (Update_SR)
   );

   condition_check u_condition_check (
      .cond    (cond),
      .SR      (SR),
      .cond_ok (cond_ok)
   );

   register_file u_register_file (
      .clk         (clk),
      .rst         (rst),
      .src1        (src1),
      .src2        (src2),
      .Dest_wb     (Dest_wb),
      .Result_WB   (Result_WB),
      .writeBackEn (writeBackEn),
      .reg1        (reg1),
      .reg2        (reg2)
   );

endmodule

// File: tb/tb_id_decode_unit.sv
// Directed bench for id_decode_unit: register file reset/write-back,
// decode sweep and full condition table.
module tb_id_decode_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [3:0]  op_code;
   logic        S;
   logic [3:0]  cond;
   logic [3:0]  SR;
   logic [3:0]  src1, src2, Dest_wb;
   logic [31:0] Result_WB;
   logic        writeBackEn;
   logic [3:0]  Execute_command;
   logic        mem_read, mem_write, WB_enable, B, Update_SR, cond_ok;
   logic [31:0] reg1, reg2;

   int n_checks = 0;
   int n_pass   = 0;

   id_decode_unit dut (
      .clk             (clk),
      .rst             (rst),
      .mode            (mode),
      .op_code         (op_code),
      .S               (S),
      .cond            (cond),
      .SR              (SR),
      .src1            (src1),
      .src2            (src2),
      .Dest_wb         (Dest_wb),
      .Result_WB       (Result_WB),
      .writeBackEn     (writeBackEn),
      .Execute_command (Execute_command),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .WB_enable       (WB_enable),
      .B               (B),
      .Update_SR       (Update_SR),
      .cond_ok         (cond_ok),
      .reg1            (reg1),
      .reg2            (reg2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   // Packed decode outputs: {cmd[3:0], mem_read, mem_write, WB, B, Update_SR}
   function automatic logic [8:0] dec_vec();
      return {Execute_command, mem_read, mem_write, WB_enable, B, Update_SR};
   endfunction

   typedef struct {
      logic [3:0] op;
      logic [3:0] cmd;
      logic       wb;
   } dp_vec_t;

   dp_vec_t dp_tab [11] = '{
      '{4'b1101, 4'b0001, 1'b1}, '{4'b1111, 4'b1001, 1'b1},
      '{4'b0100, 4'b0010, 1'b1}, '{4'b0101, 4'b0011, 1'b1},
      '{4'b0010, 4'b0100, 1'b1}, '{4'b0110, 4'b0101, 1'b1},
      '{4'b0000, 4'b0110, 1'b1}, '{4'b1100, 4'b0111, 1'b1},
      '{4'b0001, 4'b1000, 1'b1}, '{4'b1010, 4'b0100, 1'b0},
      '{4'b1000, 4'b0110, 1'b0}
   };

   // Hand-written condition table indexed by cond; flags named explicitly
   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] sr);
      logic fn, fz, fc, fv;
      {fn, fz, fc, fv} = sr;
      case (c)
         4'd0:  return fz;
         4'd1:  return !fz;
         4'd2:  return fc;
         4'd3:  return !fc;
         4'd4:  return fn;
         4'd5:  return !fn;
         4'd6:  return fv;
         4'd7:  return !fv;
         4'd8:  return fc && !fz;
         4'd9:  return !fc || fz;
         4'd10: return fn == fv;
         4'd11: return fn != fv;
         4'd12: return !fz && (fn == fv);
         4'd13: return fz || (fn != fv);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   initial begin
      rst = 1'b0; mode = 2'b11; op_code = 4'd0; S = 1'b0; cond = 4'd0; SR = 4'd0;
      src1 = 4'd0; src2 = 4'd0; Dest_wb = 4'd0; Result_WB = 32'd0; writeBackEn = 1'b0;

      #2 rst = 1'b1;
      #6 rst = 1'b0;
      @(posedge clk); #1;
      src1 = 4'd3; src2 = 4'd14; #1;
      check("rst_r3", reg1, 32'd3);
      check("rst_r14", reg2, 32'd14);
      src1 = 4'd15; #1;
      check("r15_zero", reg1, 32'd0);
      src1 = 4'd0; src2 = 4'd0; #1;
      check("rst_r0_same", reg1, 32'd0);
      check("rst_r0_same2", reg2, 32'd0);

      // Write-back visible before the next rising edge
      @(posedge clk); #1;
      Dest_wb = 4'd5; Result_WB = 32'hDEADBEEF; writeBackEn = 1'b1;
      src1 = 4'd5; src2 = 4'd5;
      #1 check("wb_before_neg", reg1, 32'd5);
      @(negedge clk); #1;
      check("wb_r5", reg1, 32'hDEADBEEF);
      check("wb_r5_port2", reg2, 32'hDEADBEEF);

      @(posedge clk); #1;
      Result_WB = 32'h01234567; writeBackEn = 1'b0;
      @(negedge clk); #1;
      check("wb_disabled", reg1, 32'hDEADBEEF);

      @(posedge clk); #1;
      Dest_wb = 4'd15; Result_WB = 32'hCAFEF00D; writeBackEn = 1'b1; src1 = 4'd15;
      @(negedge clk); #1;
      check("wb_r15_ignored", reg1, 32'd0);

      @(posedge clk); #1;
      Dest_wb = 4'd14; Result_WB = 32'h0000_00A5; src1 = 4'd14; src2 = 4'd13;
      @(negedge clk); #1;
      check("wb_r14", reg1, 32'h0000_00A5);
      check("wb_r13_untouched", reg2, 32'd13);
      writeBackEn = 1'b0;

      // Reset held across a falling edge with a pending write
      @(posedge clk); #1;
      Dest_wb = 4'd7; Result_WB = 32'h12345678; writeBackEn = 1'b1; rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      src1 = 4'd7; src2 = 4'd5; #1;
      check("midrst_r7", reg1, 32'd7);
      check("midrst_r5", reg2, 32'd5);
      writeBackEn = 1'b0;

      // Data-processing decode sweep
      mode = 2'b00;
      foreach (dp_tab[i]) begin
         for (int s = 0; s < 2; s++) begin
            op_code = dp_tab[i].op; S = s[0]; #1;
            check($sformatf("dp_op%b_s%0d", dp_tab[i].op, s), 32'(dec_vec()),
                  32'({dp_tab[i].cmd, 1'b0, 1'b0, dp_tab[i].wb, 1'b0, s[0]}));
         end
      end
      op_code = 4'b0100; S = 1'b1; #1;
      check("add_s1", 32'(dec_vec()), 32'(9'b0010_0_0_1_0_1));
      op_code = 4'b1010; S = 1'b0; #1;
      check("cmp", 32'(dec_vec()), 32'(9'b0100_0_0_0_0_0));
      op_code = 4'b0011; S = 1'b1; #1;
      check("dp_undef_s1", 32'(dec_vec()), 32'(9'b0000_0_0_0_0_1));
      op_code = 4'b1011; S = 1'b0; #1;
      check("dp_undef_s0", 32'(dec_vec()), 32'(9'b0));

      mode = 2'b01; op_code = 4'b1001; S = 1'b1; #1;
      check("ldr", 32'(dec_vec()), 32'(9'b0010_1_0_1_0_0));
      S = 1'b0; #1;
      check("str", 32'(dec_vec()), 32'(9'b0010_0_1_0_0_0));
      mode = 2'b10; S = 1'b1; op_code = 4'b0100; #1;
      check("branch", 32'(dec_vec()), 32'(9'b0000_0_0_0_1_0));
      mode = 2'b11; #1;
      check("mode11", 32'(dec_vec()), 32'(9'b0));

      // Condition table, full sweep plus spot checks
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            cond = 4'(c); SR = 4'(f); #1;
            check($sformatf("cond%0d_sr%0d", c, f), 32'(cond_ok), 32'(cond_ref(4'(c), 4'(f))));
         end
      end
      cond = 4'b1100; SR = 4'b1001; #1;
      check("gt_nv", 32'(cond_ok), 32'd1);
      cond = 4'b1100; SR = 4'b1000; #1;
      check("gt_n_not_v", 32'(cond_ok), 32'd0);
      cond = 4'b1000; SR = 4'b0010; #1;
      check("hi_c", 32'(cond_ok), 32'd1);
      cond = 4'b1111; SR = 4'b1111; #1;
      check("nv_all", 32'(cond_ok), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
